// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary decoder: multiply-by-10 accumulate, one digit per clock, MSD first.
// Optional signed output selected by defining BCD_SIGN_EN (adds neg input, widens bin_out by one bit).
module bcd_to_binary_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
`ifdef BCD_SIGN_EN
    input  logic                  neg,
`endif
    output logic                  busy,
    output logic                  done,
`ifdef BCD_SIGN_EN
    output logic [BIN_W:0]        bin_out,
`else
    output logic [BIN_W-1:0]      bin_out,
`endif
    output logic                  err
);

`ifdef BCD_SIGN_EN
    localparam int OUT_W = BIN_W + 1;
`else
    localparam int OUT_W = BIN_W;
`endif
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [4*DIGITS-1:0] r_sr;
    logic [BIN_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [OUT_W-1:0]    r_bin;
    logic                r_err;
`ifdef BCD_SIGN_EN
    logic                r_neg;
`endif

    logic [BIN_W-1:0]    w_acc_next;
    logic [OUT_W-1:0]    w_result;
    logic                w_bcd_ok;
    logic                w_last;

    // acc*10 as (acc<<3)+(acc<<1); BIN_W is sized so this never overflows
    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + BIN_W'(r_sr[4*DIGITS-1 -: 4]);
    assign w_last     = (r_state == S_CONV) && (r_cnt == CNT_W'(DIGITS - 1));

`ifdef BCD_SIGN_EN
    logic [OUT_W-1:0] w_mag;
    assign w_mag    = {1'b0, w_acc_next};
    assign w_result = r_neg ? (~w_mag + 1'b1) : w_mag;
`else
    assign w_result = w_acc_next;
`endif

    always_comb begin
        w_bcd_ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                w_bcd_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_bin   <= '0;
            r_err   <= 1'b0;
`ifdef BCD_SIGN_EN
            r_neg   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_CONV: begin
                    r_acc <= w_acc_next;
                    r_sr  <= r_sr << 4;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_bin   <= w_result;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new operand, giving back-to-back conversions
                    if (start) begin
                        r_sr  <= bcd_in;
                        r_acc <= '0;
                        r_cnt <= '0;
`ifdef BCD_SIGN_EN
                        r_neg <= neg;
`endif
                        if (!w_bcd_ok) begin
                            r_state <= S_DONE;
                            r_bin   <= '0;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_CONV;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = (r_state == S_CONV);
    assign done    = (r_state == S_DONE);
    assign bin_out = r_bin;
    assign err     = r_err;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: decimal-value model checked every cycle plus directed literals.
module tb_bcd_to_binary_seq;
    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
`ifdef BCD_SIGN_EN
    localparam int OUT_W = BIN_W + 1;
`else
    localparam int OUT_W = BIN_W;
`endif

    logic                  clk = 1'b0;
    logic                  clr = 1'b1;
    logic                  start = 1'b0;
    logic [4*DIGITS-1:0]   bcd_in = '0;
`ifdef BCD_SIGN_EN
    logic                  neg = 1'b0;
`endif
    logic                  busy;
    logic                  done;
    logic [OUT_W-1:0]      bin_out;
    logic                  err;

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;

    bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .bcd_in  (bcd_in),
`ifdef BCD_SIGN_EN
        .neg     (neg),
`endif
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    // Model: cycles of conversion remaining, and the value the operand denotes in decimal
    int               m_left = 0;
    int               m_val  = 0;
    bit               m_done = 1'b0;
    bit               m_err  = 1'b0;
    logic [OUT_W-1:0] m_bin  = '0;

    always @(posedge clk) begin
        int  v;
        bit  bad;
        if (clr) begin
            m_left = 0;
            m_done = 1'b0;
            m_err  = 1'b0;
            m_bin  = '0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
            if (m_left == 0) begin
                m_bin = OUT_W'(m_val);
                m_err = 1'b0;
            end
        end else if (start) begin
            v   = 0;
            bad = 1'b0;
            for (int i = DIGITS - 1; i >= 0; i--) begin
                if (bcd_in[4*i +: 4] > 4'd9) bad = 1'b1;
                v = v * 10 + int'(bcd_in[4*i +: 4]);
            end
`ifdef BCD_SIGN_EN
            if (neg) v = -v;
`endif
            if (bad) begin
                m_done = 1'b1;
                m_err  = 1'b1;
                m_bin  = '0;
            end else begin
                m_val  = v;
                m_left = DIGITS;
                m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",    32'(busy),    32'(m_left > 0));
            chk("done",    32'(done),    32'(m_done));
            chk("bin_out", 32'(bin_out), 32'(m_bin));
            chk("err",     32'(err),     32'(m_err));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Pulse start for one cycle, then wait (bounded) for done and check its timing and result
    task automatic conv(input logic [15:0] v, input bit n, input logic [31:0] exp_bin,
                        input bit exp_err, input int exp_lat);
        int lat = 0;
        start  = 1'b1;
        bcd_in = v;
`ifdef BCD_SIGN_EN
        neg    = n;
`else
        if (n) $display("note: neg ignored in unsigned build");
`endif
        do begin
            tick();
            if (lat == 0) start = 1'b0;
            lat++;
        end while (!done && lat < 20);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("lit_bin", 32'(bin_out), exp_bin);
        chk("lit_err", 32'(err), 32'(exp_err));
        tick();
        chk("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        int dones;
        tick();
        tick();
        clr = 1'b0;
        cmp_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bin",  32'(bin_out), 32'd0);
        chk("rst_err",  32'(err), 32'd0);

        // Full-scale operand: busy cycles 1..4, done in cycle 5
        start = 1'b1; bcd_in = 16'h9999;
        tick(); start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("busy_9999", 32'(busy), 32'd1);
            tick();
        end
        chk("done_9999", 32'(done), 32'd1);
        chk("bin_9999",  32'(bin_out), 32'h270F);
        chk("err_9999",  32'(err), 32'd0);
        tick();

        conv(16'h0000, 1'b0, 32'd0,    1'b0, 5);
        conv(16'h0042, 1'b0, 32'h2A,   1'b0, 5);
        conv(16'h12A4, 1'b0, 32'd0,    1'b1, 1);
        conv(16'h1234, 1'b0, 32'd1234, 1'b0, 5);

        // start during CONV ignored; start on the done cycle accepted
        start = 1'b1; bcd_in = 16'h0500;
        tick(); start = 1'b0;
        tick(); start = 1'b1; bcd_in = 16'h9999;
        tick(); start = 1'b0;
        tick();
        tick();
        chk("done_500", 32'(done), 32'd1);
        chk("bin_500",  32'(bin_out), 32'd500);
        start = 1'b1; bcd_in = 16'h0007;
        tick(); start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        tick(); tick(); tick(); tick();
        chk("done_7", 32'(done), 32'd1);
        chk("bin_7",  32'(bin_out), 32'd7);
        tick();

        // clr mid-conversion abandons it with no done pulse
        start = 1'b1; bcd_in = 16'h8765;
        tick(); start = 1'b0;
        tick();
        tick(); clr = 1'b1;
        tick(); clr = 1'b0;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_bin",  32'(bin_out), 32'd0);
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) dones++;
            tick();
        end
        chk("clr_no_done", 32'(dones), 32'd0);
        conv(16'h0001, 1'b0, 32'd1, 1'b0, 5);

`ifdef BCD_SIGN_EN
        conv(16'h0123, 1'b1, 32'h7F85, 1'b0, 5);
        conv(16'h0000, 1'b1, 32'd0,    1'b0, 5);
        conv(16'h0456, 1'b0, 32'd456,  1'b0, 5);
`endif

        tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
